// File: rtl/regfile.sv
// ============================================================================
//  Module      : regfile
//  Description : 32 x 32-bit general-purpose register file with one
//                synchronous write port, two combinational read ports and
//                register 0 hardwired to zero. Compile-time macro
//                REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_wen_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    input  logic        id_re1_i,
    input  logic [4:0]  id_raddr1_i,
    output logic [31:0] id_rdata1_o,
    input  logic        id_re2_i,
    input  logic [4:0]  id_raddr2_i,
    output logic [31:0] id_rdata2_o
);

    localparam int          c_DEPTH = 32;
    localparam int          c_WIDTH = 32;
    localparam logic [4:0]  c_ZERO_IDX = 5'd0;

    logic [c_WIDTH-1:0] r_regs_q [c_DEPTH];
    logic [c_WIDTH-1:0] w_regs_d [c_DEPTH];
    logic               w_wr_hit;

    // A write needs enable and a nonzero index; index 0 never takes data.
    assign w_wr_hit = wb_wen_i && (wb_waddr_i != c_ZERO_IDX);

    always_comb begin
        w_regs_d = r_regs_q;
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                w_regs_d[i] = '0;
            end
        end else if (w_wr_hit) begin
            w_regs_d[wb_waddr_i] = wb_wdata_i;
        end
        w_regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_DEPTH; i++) begin
            r_regs_q[i] <= w_regs_d[i];
        end
    end

    function automatic logic [c_WIDTH-1:0] f_read(
        input logic       i_re,
        input logic [4:0] i_addr
    );
        logic [c_WIDTH-1:0] v_data;
        v_data = '0;
        if (rst || !i_re || (i_addr == c_ZERO_IDX)) begin
            v_data = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (wb_wen_i && (wb_waddr_i == i_addr)) begin
            v_data = wb_wdata_i;
`endif
        end else begin
            v_data = r_regs_q[i_addr];
        end
        return v_data;
    endfunction

    assign id_rdata1_o = f_read(id_re1_i, id_raddr1_i);
    assign id_rdata2_o = f_read(id_re2_i, id_raddr2_i);

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
//  Module      : tb_regfile
//  Description : Directed self-checking bench for regfile; expectations track
//                REGFILE_BYPASS_EN when it is defined for the build.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_wen_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        id_re1_i;
    logic [4:0]  id_raddr1_i;
    logic [31:0] id_rdata1_o;
    logic        id_re2_i;
    logic [4:0]  id_raddr2_i;
    logic [31:0] id_rdata2_o;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    regfile u_dut (
        .clk         (clk),
        .rst         (rst),
        .wb_wen_i    (wb_wen_i),
        .wb_waddr_i  (wb_waddr_i),
        .wb_wdata_i  (wb_wdata_i),
        .id_re1_i    (id_re1_i),
        .id_raddr1_i (id_raddr1_i),
        .id_rdata1_o (id_rdata1_o),
        .id_re2_i    (id_re2_i),
        .id_raddr2_i (id_raddr2_i),
        .id_rdata2_o (id_rdata2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; the write lands on the next rising edge.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        wb_wen_i   = 1'b1;
        wb_waddr_i = addr;
        wb_wdata_i = data;
        @(negedge clk);
        wb_wen_i   = 1'b0;
    endtask

    task automatic set_read(input logic re1, input logic [4:0] a1,
                            input logic re2, input logic [4:0] a2);
        id_re1_i    = re1;
        id_raddr1_i = a1;
        id_re2_i    = re2;
        id_raddr2_i = a2;
        #1;
    endtask

    initial begin
        logic [31:0] pat;
        rst = 1'b1;
        wb_wen_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
        id_re1_i = 1'b1; id_raddr1_i = 5'd5;
        id_re2_i = 1'b1; id_raddr2_i = 5'd5;

        // Outputs held at zero while reset is asserted, even with re=1
        @(negedge clk);
        set_read(1'b1, 5'd5, 1'b1, 5'd5);
        check("rst_out_p1", id_rdata1_o, 32'h0);
        check("rst_out_p2", id_rdata2_o, 32'h0);
        rst = 1'b0;

        // Reset clears a preloaded entry
        write_reg(5'd5, 32'h1234_5678);
        set_read(1'b1, 5'd5, 1'b1, 5'd5);
        check("preload_r5", id_rdata1_o, 32'h1234_5678);
        rst = 1'b1;
        #1;
        check("rst_active_p1", id_rdata1_o, 32'h0);
        check("rst_active_p2", id_rdata2_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_read(1'b1, 5'd5, 1'b1, 5'd5);
        check("rst_clear_p1", id_rdata1_o, 32'h0);
        check("rst_clear_p2", id_rdata2_o, 32'h0);

        // Basic write then read on both ports, then disable port 2
        write_reg(5'd8, 32'hDEAD_BEEF);
        set_read(1'b1, 5'd8, 1'b1, 5'd8);
        check("wr8_p1", id_rdata1_o, 32'hDEAD_BEEF);
        check("wr8_p2", id_rdata2_o, 32'hDEAD_BEEF);
        set_read(1'b1, 5'd8, 1'b0, 5'd8);
        check("re2_off_p1", id_rdata1_o, 32'hDEAD_BEEF);
        check("re2_off_p2", id_rdata2_o, 32'h0);
        set_read(1'b0, 5'd8, 1'b1, 5'd8);
        check("re1_off_p1", id_rdata1_o, 32'h0);

        // Register 0 ignores writes, including during the write cycle
        @(negedge clk);
        wb_wen_i = 1'b1; wb_waddr_i = 5'd0; wb_wdata_i = 32'hFFFF_FFFF;
        set_read(1'b1, 5'd0, 1'b1, 5'd0);
        check("r0_during_p1", id_rdata1_o, 32'h0);
        check("r0_during_p2", id_rdata2_o, 32'h0);
        @(negedge clk);
        wb_wen_i = 1'b0;
        set_read(1'b1, 5'd0, 1'b1, 5'd0);
        check("r0_after_p1", id_rdata1_o, 32'h0);
        check("r0_after_p2", id_rdata2_o, 32'h0);

        // Same-cycle write and read of one index
        write_reg(5'd3, 32'h0000_0011);
        @(negedge clk);
        wb_wen_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'h0000_0022;
        set_read(1'b1, 5'd3, 1'b1, 5'd8);
        check("hazard_same", id_rdata1_o, c_BYPASS ? 32'h0000_0022 : 32'h0000_0011);
        check("hazard_other", id_rdata2_o, 32'hDEAD_BEEF);
        @(negedge clk);
        wb_wen_i = 1'b0;
        set_read(1'b1, 5'd3, 1'b1, 5'd3);
        check("hazard_next_p1", id_rdata1_o, 32'h0000_0022);
        check("hazard_next_p2", id_rdata2_o, 32'h0000_0022);

        // Write disabled: stored value stays, nothing forwarded
        write_reg(5'd7, 32'h0000_0001);
        @(negedge clk);
        wb_wen_i = 1'b0; wb_waddr_i = 5'd7; wb_wdata_i = 32'hA5A5_A5A5;
        set_read(1'b1, 5'd7, 1'b1, 5'd7);
        check("wen0_same_p1", id_rdata1_o, 32'h0000_0001);
        check("wen0_same_p2", id_rdata2_o, 32'h0000_0001);
        @(negedge clk);
        set_read(1'b1, 5'd7, 1'b1, 5'd7);
        check("wen0_next", id_rdata1_o, 32'h0000_0001);

        // Back-to-back writes to one index: last one holds
        @(negedge clk);
        wb_wen_i = 1'b1; wb_waddr_i = 5'd10; wb_wdata_i = 32'h0000_000A;
        @(negedge clk);
        wb_wdata_i = 32'h0000_000B;
        set_read(1'b1, 5'd10, 1'b1, 5'd10);
        check("b2b_between", id_rdata1_o, c_BYPASS ? 32'h0000_000B : 32'h0000_000A);
        @(negedge clk);
        wb_wen_i = 1'b0;
        set_read(1'b1, 5'd10, 1'b1, 5'd10);
        check("b2b_final", id_rdata2_o, 32'h0000_000B);

        // Reset wins over a simultaneous write
        @(negedge clk);
        rst = 1'b1; wb_wen_i = 1'b1; wb_waddr_i = 5'd9; wb_wdata_i = 32'h0000_0055;
        set_read(1'b1, 5'd9, 1'b1, 5'd9);
        check("rst_wr_during", id_rdata1_o, 32'h0);
        @(negedge clk);
        rst = 1'b0; wb_wen_i = 1'b0;
        set_read(1'b1, 5'd9, 1'b1, 5'd8);
        check("rst_wr_r9", id_rdata1_o, 32'h0);
        check("rst_wr_r8", id_rdata2_o, 32'h0);

        // Fill every register with a distinct pattern, then read all back
        for (int i = 1; i < 32; i++) begin
            pat = {8'(i), 8'(~i), 8'(i * 3), 8'(i ^ 8'h5A)};
            write_reg(5'(i), pat);
        end
        for (int i = 1; i < 32; i++) begin
            pat = {8'(i), 8'(~i), 8'(i * 3), 8'(i ^ 8'h5A)};
            set_read(1'b1, 5'(i), 1'b1, 5'(32 - i));
            check("fill_p1", id_rdata1_o, pat);
            pat = {8'(32 - i), 8'(~(32 - i)), 8'((32 - i) * 3), 8'((32 - i) ^ 8'h5A)};
            check("fill_p2", id_rdata2_o, pat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
